// File: rtl/fanin_pkg.sv
// Shared definitions for the child fan-in collector and its round-robin arbiter.
package fanin_pkg;

  localparam int DEF_NUM_CHILD = 5;
  localparam int DEF_DATA_W    = 16;

  // Width of a child index; never narrower than one bit.
  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Upstream word {src, data} at the default configuration.
  typedef struct packed {
    logic [src_w(DEF_NUM_CHILD)-1:0] src;
    logic [DEF_DATA_W-1:0]           data;
  } out_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr.
module rr_arbiter
  import fanin_pkg::*;
#(
  parameter  int N     = DEF_NUM_CHILD,
  localparam int PTR_W = src_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;

  // Search req starting at rr_ptr_q, wrapping modulo N; first hit wins.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr_q) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

  // Priority moves to the child just after the one granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      rr_ptr_d = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Pointer register with synchronous reset to child 0.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/child_fanin_collector.sv
// Merges NUM_CHILD child request streams into one upstream stream tagged
// with the source child index, through a single registered output slot.
module child_fanin_collector
  import fanin_pkg::*;
#(
  parameter  int NUM_CHILD = DEF_NUM_CHILD,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int CNT_W     = 16,
  localparam int SRC_W     = src_w(NUM_CHILD)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CHILD-1:0]        child_valid,
  input  logic [NUM_CHILD*DATA_W-1:0] child_data,
  output logic [NUM_CHILD-1:0]        child_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [SRC_W-1:0]            out_src,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            xfer_cnt
);

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } word_t;

  logic                 slot_free;
  logic                 up_hs;
  logic                 any_grant;
  logic [NUM_CHILD-1:0] req;
  logic [NUM_CHILD-1:0] grant;
  logic [SRC_W-1:0]     grant_idx;
  logic [DATA_W-1:0]    grant_data;

  logic                 out_valid_q, out_valid_d;
  word_t                word_q,      word_d;
  logic [CNT_W-1:0]     xfer_cnt_q,  xfer_cnt_d;

  // The slot can take a word when empty or being drained this cycle; the
  // request mask is the only path from out_ready into the grant.
  assign slot_free = !out_valid_q || out_ready;
  assign req       = (slot_free && !rst) ? child_valid : '0;
  assign up_hs     = out_valid_q && out_ready;
  assign any_grant = |grant;

  rr_arbiter #(.N(NUM_CHILD)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .advance   (any_grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // AND-OR select of the granted child's payload.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      grant_data = grant_data | (child_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
    end
  end

  // Output slot: reload on grant (also covers drain-and-refill in one
  // cycle), empty on a drain with no grant, otherwise hold.
  always_comb begin
    word_d      = word_q;
    out_valid_d = out_valid_q;
    if (any_grant) begin
      word_d.src  = grant_idx;
      word_d.data = grant_data;
      out_valid_d = 1'b1;
    end else if (up_hs) begin
      out_valid_d = 1'b0;
    end
  end

  // Saturating count of upstream handshakes.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (up_hs && (xfer_cnt_q != '1)) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops any held word without reporting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      word_q      <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      word_q      <= word_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign child_ready = grant;
  assign out_valid   = out_valid_q;
  assign out_data    = word_q.data;
  assign out_src     = word_q.src;
  assign xfer_cnt    = xfer_cnt_q;

endmodule

// File: tb/tb_child_fanin_collector.sv
// Self-checking bench: cycle-level behavioural model plus directed scenarios
// and randomized traffic. A second instance with a 4-bit counter shares all
// inputs to exercise counter saturation.
module tb_child_fanin_collector;

  localparam int N  = 5;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    child_valid;
  logic [N*DW-1:0] child_data;
  logic [N-1:0]    child_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_src;
  logic            out_ready;
  logic [15:0]     xfer_cnt;

  logic [N-1:0]    child_ready4;
  logic            out_valid4;
  logic [DW-1:0]   out_data4;
  logic [2:0]      out_src4;
  logic [3:0]      xfer_cnt4;

  child_fanin_collector #(.NUM_CHILD(N), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .child_valid(child_valid), .child_data(child_data),
    .child_ready(child_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  child_fanin_collector #(.NUM_CHILD(N), .DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .child_valid(child_valid), .child_data(child_data),
    .child_ready(child_ready4), .out_valid(out_valid4), .out_data(out_data4),
    .out_src(out_src4), .out_ready(out_ready), .xfer_cnt(xfer_cnt4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_ptr   = 0;
  bit m_valid = 1'b0;
  int m_data  = 0;
  int m_src   = 0;
  int m_total = 0;
  int g_log[$];
  int hs_src[$];
  int hs_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int child_word(input int i);
    logic [N*DW-1:0] d;
    d = child_data;
    return int'(d[i*DW +: DW]);
  endfunction

  // One clock: predict and compare outputs mid-cycle, then advance the model
  // at the rising edge. Inputs must be stable when this is called.
  task automatic cycle();
    int g;
    int idx;
    logic [N-1:0] exp_r;
    @(negedge clk);
    g     = -1;
    exp_r = '0;
    if (!rst && (!m_valid || out_ready)) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && child_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_r[g] = 1'b1;
    check("child_ready", 32'(child_ready), 32'(exp_r));
    check("out_valid",   32'(out_valid),   32'(m_valid));
    check("out_data",    32'(out_data),    32'(m_data));
    check("out_src",     32'(out_src),     32'(m_src));
    check("xfer_cnt",    32'(xfer_cnt),    32'((m_total > 65535) ? 65535 : m_total));
    check("xfer_cnt4",   32'(xfer_cnt4),   32'((m_total > 15) ? 15 : m_total));
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_valid = 1'b0; m_data = 0; m_src = 0; m_total = 0;
    end else begin
      if (m_valid && out_ready) begin
        m_total++;
        hs_src.push_back(m_src);
        hs_data.push_back(m_data);
      end
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = child_word(g);
        m_src   = g;
        m_ptr   = (g + 1) % N;
        g_log.push_back(g);
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic clear_logs();
    g_log.delete();
    hs_src.delete();
    hs_data.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; child_valid = '0; out_ready = 1'b0; child_data = '0;
    cycle();
    cycle();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic set_child(input int i, input int val);
    child_data[i*DW +: DW] = DW'(val);
  endtask

  initial begin
    rst = 1'b1; child_valid = '0; child_data = '0; out_ready = 1'b0;
    #1;

    // Reset held 3 cycles with every child valid.
    child_valid = '1;
    for (int i = 0; i < N; i++) set_child(i, 16'h1000 + i);
    for (int c = 0; c < 3; c++) cycle();
    check("rst_ready", 32'(child_ready), 32'h0);
    rst = 1'b0;
    clear_logs();
    cycle();
    check("first_grant_cnt", 32'(g_log.size()), 32'd1);
    if (g_log.size() > 0) check("first_grant_idx", 32'(g_log[0]), 32'd0);

    // Single child 3 streaming 10 words.
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      child_valid = 5'b01000;
      set_child(3, 16'hA000 + n);
      cycle();
    end
    child_valid = '0;
    cycle();
    check("c3_words", 32'(hs_src.size()), 32'd10);
    for (int n = 0; n < 10 && n < hs_src.size(); n++) begin
      check("c3_src",  32'(hs_src[n]),  32'd3);
      check("c3_data", 32'(hs_data[n]), 32'(16'hA000 + n));
    end
    check("c3_xfer", 32'(xfer_cnt), 32'd10);

    // All children valid: strict rotation, no gaps.
    do_reset();
    out_ready   = 1'b1;
    child_valid = '1;
    for (int c = 0; c < 16; c++) cycle();
    check("rot_count", 32'(hs_src.size()), 32'd15);
    for (int n = 0; n < hs_src.size(); n++) check("rot_src", 32'(hs_src[n]), 32'(n % N));

    // Children 1 and 4 with a 4-cycle stall after the first grant.
    do_reset();
    child_valid = 5'b10010;
    for (int i = 0; i < N; i++) set_child(i, 16'hB000 + i);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("stall_ready", 32'(child_ready), 32'h0);
      check("stall_data",  32'(out_data),    32'hB001);
      check("stall_src",   32'(out_src),     32'd1);
    end
    out_ready = 1'b1;
    cycle();
    cycle();
    check("bp_grants", 32'(g_log.size()), 32'd3);
    if (g_log.size() == 3) begin
      check("bp_g0", 32'(g_log[0]), 32'd1);
      check("bp_g1", 32'(g_log[1]), 32'd4);
      check("bp_g2", 32'(g_log[2]), 32'd1);
    end

    // Reset while a word is held under backpressure.
    do_reset();
    child_valid = 5'b00100;
    set_child(2, 16'hC0DE);
    cycle();
    child_valid = '0;
    cycle();
    check("held_valid", 32'(out_valid), 32'd1);
    clear_logs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    check("discard_hs", 32'(hs_src.size()), 32'd0);
    check("discard_cnt", 32'(xfer_cnt), 32'd0);
    child_valid = '1;
    cycle();
    check("ptr_reset_grants", 32'(g_log.size()), 32'd1);
    if (g_log.size() == 1) check("ptr_reset_idx", 32'(g_log[0]), 32'd0);

    // 4-bit counter saturation over 20+ transfers.
    do_reset();
    out_ready   = 1'b1;
    child_valid = 5'b00001;
    for (int c = 0; c < 22; c++) cycle();
    check("sat_cnt4", 32'(xfer_cnt4), 32'd15);
    check("sat_cnt16", 32'(xfer_cnt), 32'd21);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      child_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_child(i, int'($urandom_range(0, 65535)));
      out_ready   = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/child_fanin_collector.md
# child_fanin_collector

Fan-in collector that merges request streams from the five leaf instances under a generated hierarchy node into a single upstream stream toward the parent node. It is the upward return path that complements the node's downward fan-out of instances. Each word is tagged with its source child index. A round-robin arbiter grants one child per cycle, and a registered output stage sustains full throughput under backpressure.

## Interface
Parameters:
- NUM_CHILD, 5, number of child streams (2..16)
- DATA_W, 16, payload width per word
- CNT_W, 16, width of the transferred-word counter

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- child_valid  in  NUM_CHILD  per-child word available
- child_data  in  NUM_CHILD*DATA_W  packed payloads; child i occupies bits [i*DATA_W +: DATA_W]
- child_ready  out  NUM_CHILD  one-hot or zero; child i word accepted when child_valid[i] && child_ready[i]
- out_valid  out  1  upstream word available
- out_data  out  DATA_W  upstream payload
- out_src  out  SRC_W  index of the child that produced out_data; SRC_W = $clog2(NUM_CHILD)
- out_ready  in  1  upstream accepts when out_valid && out_ready
- xfer_cnt  out  CNT_W  count of upstream transfers; saturates at all-ones

## Operation
- slot_free = !out_valid || out_ready.
- Grant request vector = child_valid masked by slot_free.
  - Granting never depends on out_ready through any other path.
- Round-robin pointer rr_ptr names the highest-priority child.
  - Grant goes to the first requesting child searching rr_ptr, rr_ptr+1, … with wrap modulo NUM_CHILD.
- child_ready is combinational:
  - It is the one-hot grant when slot_free and at least one child is valid.
  - Otherwise it is all zero.
  - child_ready is never asserted to a child whose valid is low.
- On a grant to child g:
  - out_data ← child_data[g]
  - out_src ← g
  - out_valid ← 1
  - rr_ptr ← (g+1) mod NUM_CHILD
- When the upstream handshake completes and there is no grant in the same cycle:
  - out_valid ← 0.
  - out_data and out_src hold their last value.
- Simultaneous upstream handshake and grant: the slot is reloaded with no bubble, giving throughput of 1 word/cycle.
- No grant: rr_ptr holds.
- While out_valid && !out_ready:
  - out_data and out_src are stable.
  - child_ready is zero.
- xfer_cnt increments on each upstream handshake and saturates at 2^CNT_W−1.
- Reset values:
  - out_valid=0, out_data=0, out_src=0
  - rr_ptr=0
  - xfer_cnt=0
  - child_ready=0 during the reset cycle
- Reset asserted mid-transfer discards a held word; it is not reported upstream.

## Timing
- Latency: child accept at cycle N → out_valid at cycle N+1.
- A single active child with out_ready held high streams one word per cycle.
- With k children continuously valid and out_ready high, each child receives exactly one grant every k cycles.
- Backpressure propagates to child_ready combinationally in the same cycle; the module holds no extra buffering beyond the single output register.
- Upstream valid/ready rules:
  - out_valid, once high, stays high until a handshake.
  - Data is stable while stalled.

## Structure
- A shared package (fanin_pkg) holds:
  - default NUM_CHILD and DATA_W
  - an SRC_W helper function
  - a typedef for the {src, data} output word
- Sub-module rr_arbiter (parameter N) contains:
  - inputs req[N] and advance
  - outputs a one-hot grant[N] and grant_idx
  - the rr_ptr register, updated when advance is high
- child_fanin_collector holds the output register, handshake logic and counter.

## Test plan
- Reset held 3 cycles with all child_valid=1: during reset child_ready=0, out_valid=0, xfer_cnt=0; first grant after reset goes to child 0.
- Only child 3 valid, data 0xA000+n, out_ready=1 for 10 cycles: 10 consecutive words, out_src=3, data in order, xfer_cnt=10.
- All 5 children valid continuously, out_ready=1: out_src sequence 0,1,2,3,4,0,1,… with no gaps.
- Children 1 and 4 valid, out_ready low for 4 cycles after the first grant: out_data/out_src frozen and child_ready=0 throughout; after release, the next grant is 4, then 1.
- Reset asserted while out_valid=1 and out_ready=0: next cycle out_valid=0, rr_ptr=0, xfer_cnt=0; the held word never appears.
- CNT_W=4, 20 transfers: xfer_cnt reaches 15 and holds at 15.
